axi_cdc_src_isolate: RTL
========================

Name: axi_cdc_src_isolate

Overview:
- Single-clock AXI gate in the source clock domain, directly upstream of the AXI CDC source half.
- Counts outstanding write and read transactions.
- On request, stops new AW/AR from entering the CDC, waits until every outstanding transaction has drained, then reports the crossing as quiescent.
- Software or a power controller uses this before gating or resetting the destination clock domain.

Parameters:
- MaxTxn, 8: maximum outstanding transactions per direction (writes, reads); CntW = $clog2(MaxTxn+1).
- TimeoutCycles, 1024: DRAIN cycles before timeout_o fires (optional feature only).
- axi_req_t, logic: AXI request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- axi_resp_t, logic: AXI response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).

Ports:
- src_clk_i  in  1  source-domain clock.
- src_rst_ni  in  1  asynchronous reset, active low.
- isolate_i  in  1  request isolation; level-sensitive.
- isolated_o  out  1  high only in ISOLATED.
- slv_req_i  in  axi_req_t  from upstream master.
- slv_resp_o  out  axi_resp_t  to upstream master.
- mst_req_o  out  axi_req_t  to CDC source half.
- mst_resp_i  in  axi_resp_t  from CDC source half.
- timeout_o  out  1  drain timeout flag (present only with the optional feature).

Behaviour:
- Interface: one clock, src_clk_i; reset src_rst_ni is asynchronous, active low.
- Reset values: state=NORMAL, all counters 0, hold flags 0, isolated_o=0, timeout_o=0.
- Pass-through: payloads (aw, w, ar, b, r) are combinational pass-through with zero latency. B and R channels always pass unmodified.
- wr_cnt: +1 on mst AW handshake, -1 on mst B handshake. Simultaneous handshakes leave it unchanged.
- rd_cnt: +1 on AR handshake, -1 on R handshake with r.last=1. Simultaneous handshakes leave it unchanged.
- w_open: +1 on AW handshake, -1 on W handshake with w.last=1. Net 0 when both occur in the same cycle. Signed, CntW+1 bits, because W may lead AW.
- aw_allow = (state==NORMAL && wr_cnt<MaxTxn) || aw_hold.
- AW gating: mst aw_valid = slv aw_valid & aw_allow; slv aw_ready = mst aw_ready & aw_allow.
- AR gating: same as AW, using rd_cnt and ar_hold.
- aw_hold (and ar_hold): set when the gated valid is high and ready is low; cleared on the handshake. This guarantees valid is never withdrawn once presented downstream, even if state leaves NORMAL.
- W gating:
  - NORMAL: W passes.
  - DRAIN/ISOLATED: W passes only while w_open>0 or a W burst is mid-transfer (w_hold, set on a non-last W handshake, cleared on the last beat). Otherwise mst w_valid=0 and slv w_ready=0.
- FSM:
  - NORMAL -> DRAIN when isolate_i=1.
  - DRAIN -> ISOLATED when wr_cnt==0, rd_cnt==0, w_open==0, and no hold flags are set, evaluated on the registered values.
  - DRAIN -> NORMAL when isolate_i=0; this has priority over entering ISOLATED.
  - ISOLATED -> NORMAL when isolate_i=0.
- isolated_o is registered: it rises the cycle after the DRAIN->ISOLATED condition and falls the cycle after isolate_i drops.
- Idle isolate: if isolate_i rises with everything idle, isolated_o rises 2 cycles later (NORMAL->DRAIN->ISOLATED).
- Saturation: at wr_cnt==MaxTxn, new AW is stalled (the counter never exceeds MaxTxn). A B handshake in the same cycle does not unblock AW until the next cycle. The same rule applies to rd_cnt.
- Underflow (B or last-R with a zero counter) is a protocol violation: simulation assertion fires; RTL holds the counter at 0.
- Reset mid-operation clears all state; upstream and downstream are reset together by convention.

Optional Feature:
- Macro AXI_CDC_SRC_ISOLATE_TIMEOUT_EN.
- When defined:
  - Adds timeout_o and a drain cycle counter, cleared on DRAIN entry and incremented each cycle in DRAIN.
  - timeout_o goes high (sticky) when the counter reaches TimeoutCycles.
  - timeout_o clears when the FSM leaves DRAIN.
  - The FSM itself is unaffected.
- When undefined: no timeout_o port, no counter logic.

Test Plan:
- Idle, isolate_i=1 at cycle 0 -> isolated_o=1 at cycle 2; slv AW/AR/W ready=0 afterward; isolate_i=0 -> isolated_o=0 next cycle, traffic resumes.
- 3 AW + 3 write bursts (len 3) accepted, isolate_i=1, B responses returned at cycles 10/12/14 -> isolated_o=1 at cycle 16; a 4th AW is never forwarded.
- AW presented with mst aw_ready=0, isolate_i asserted next cycle -> mst aw_valid stays 1 until handshake; wr_cnt=1; isolation only after its B.
- MaxTxn=8, 8 ARs with no R returned -> 9th AR stalled, slv ar_ready=0; one R with last=1 -> 9th AR accepted next cycle.
- Same-cycle AW handshake and B handshake with wr_cnt=2 -> wr_cnt stays 2.
- With AXI_CDC_SRC_ISOLATE_TIMEOUT_EN, TimeoutCycles=16, one read never answered, isolate_i=1 -> timeout_o=1 after 16 DRAIN cycles; isolate_i=0 -> timeout_o=0 next cycle.

Source files
------------

// File: rtl/axi_cdc_src_isolate.sv
// -----------------------------------------------------------------------------
// axi_cdc_src_isolate
//
// Source-domain AXI gate placed directly in front of the AXI CDC source half.
// It counts outstanding writes and reads. When isolation is requested it stops
// new AW/AR from entering the crossing and waits for all outstanding traffic to
// drain. It then reports the crossing as quiescent, so the destination domain
// can be clock-gated or reset.
//
// Optional feature (define AXI_CDC_SRC_ISOLATE_TIMEOUT_EN):
//   adds the TimeoutCycles parameter, the timeout_o port and a drain cycle
//   counter. timeout_o is a sticky flag raised after TimeoutCycles cycles in
//   DRAIN. It clears when the FSM leaves DRAIN.
//
// Ports:
//   src_clk_i   source-domain clock
//   src_rst_ni  asynchronous reset, active low
//   isolate_i   level-sensitive isolation request
//   isolated_o  high only while the FSM is in ISOLATED (register decode)
//   slv_req_i   AXI request from the upstream master
//   slv_resp_o  AXI response to the upstream master
//   mst_req_o   AXI request to the CDC source half
//   mst_resp_i  AXI response from the CDC source half
//   timeout_o   drain timeout flag (only with AXI_CDC_SRC_ISOLATE_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package axi_cdc_src_isolate_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } ax_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;

   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      logic    ar_ready;
      r_chan_t r;
      logic    r_valid;
   } axi_resp_t;

endpackage

module axi_cdc_src_isolate #(
   parameter int unsigned MaxTxn = 8,
`ifdef AXI_CDC_SRC_ISOLATE_TIMEOUT_EN
   parameter int unsigned TimeoutCycles = 1024,
`endif
   parameter type axi_req_t  = axi_cdc_src_isolate_pkg::axi_req_t,
   parameter type axi_resp_t = axi_cdc_src_isolate_pkg::axi_resp_t
) (
   input  logic      src_clk_i,
   input  logic      src_rst_ni,
   input  logic      isolate_i,
   output logic      isolated_o,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o,
   output axi_req_t  mst_req_o,
   input  axi_resp_t mst_resp_i
`ifdef AXI_CDC_SRC_ISOLATE_TIMEOUT_EN
   ,
   output logic      timeout_o
`endif
);

   localparam int unsigned CntW = $clog2(MaxTxn + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxn);
   localparam logic signed [CntW:0] WOne = 1;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        wr_cnt_q, wr_cnt_d;
   logic [CntW-1:0]        rd_cnt_q, rd_cnt_d;
   // W may arrive before its AW, so the open-burst balance can go negative.
   logic signed [CntW:0]   w_open_q, w_open_d;
   logic                   aw_hold_q, aw_hold_d;
   logic                   ar_hold_q, ar_hold_d;
   logic                   w_hold_q, w_hold_d;

   logic aw_allow, ar_allow, w_allow;
   logic aw_hs, ar_hs, w_hs, w_last_hs, b_hs, r_last_hs;
   logic quiet;

   // Channel gating. Payloads and the B/R channels pass straight through.
   always_comb begin
      aw_allow = ((state_q == NORMAL) && (wr_cnt_q < MaxCnt)) || aw_hold_q;
      ar_allow = ((state_q == NORMAL) && (rd_cnt_q < MaxCnt)) || ar_hold_q;
      // Outside NORMAL, W may only finish bursts whose AW already crossed.
      w_allow  = (state_q == NORMAL) || (!w_open_q[CntW] && (w_open_q != '0)) || w_hold_q;

      mst_req_o          = slv_req_i;
      mst_req_o.aw_valid = slv_req_i.aw_valid & aw_allow;
      mst_req_o.ar_valid = slv_req_i.ar_valid & ar_allow;
      mst_req_o.w_valid  = slv_req_i.w_valid & w_allow;

      slv_resp_o          = mst_resp_i;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
      slv_resp_o.w_ready  = mst_resp_i.w_ready & w_allow;
   end

   assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
   assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
   assign w_hs      = mst_req_o.w_valid & mst_resp_i.w_ready;
   assign w_last_hs = w_hs & slv_req_i.w.last;
   assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
   assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

   // Outstanding counters. Underflow is held at zero.
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      if (aw_hs && !b_hs) begin
         if (wr_cnt_q != MaxCnt) wr_cnt_d = wr_cnt_q + 1'b1;
      end else if (!aw_hs && b_hs) begin
         if (wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;
      end

      rd_cnt_d = rd_cnt_q;
      if (ar_hs && !r_last_hs) begin
         if (rd_cnt_q != MaxCnt) rd_cnt_d = rd_cnt_q + 1'b1;
      end else if (!ar_hs && r_last_hs) begin
         if (rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 1'b1;
      end

      w_open_d = w_open_q;
      if (aw_hs && !w_last_hs)      w_open_d = w_open_q + WOne;
      else if (!aw_hs && w_last_hs) w_open_d = w_open_q - WOne;
   end

   // Hold flags keep a presented valid alive until its handshake, even after
   // the FSM has left NORMAL.
   always_comb begin
      aw_hold_d = aw_hold_q;
      if (aw_hs)                                                aw_hold_d = 1'b0;
      else if (mst_req_o.aw_valid && !mst_resp_i.aw_ready)      aw_hold_d = 1'b1;

      ar_hold_d = ar_hold_q;
      if (ar_hs)                                                ar_hold_d = 1'b0;
      else if (mst_req_o.ar_valid && !mst_resp_i.ar_ready)      ar_hold_d = 1'b1;

      w_hold_d = w_hold_q;
      if (w_hs) w_hold_d = !slv_req_i.w.last;
   end

   assign quiet = (wr_cnt_q == '0) && (rd_cnt_q == '0) && (w_open_q == '0) &&
                  !aw_hold_q && !ar_hold_q && !w_hold_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         NORMAL:   if (isolate_i) state_d = DRAIN;
         DRAIN: begin
            // Dropping the request wins over completing the drain.
            if (!isolate_i) state_d = NORMAL;
            else if (quiet) state_d = ISOLATED;
         end
         ISOLATED: if (!isolate_i) state_d = NORMAL;
         default:  state_d = NORMAL;
      endcase
   end

   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         state_q   <= NORMAL;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         w_open_q  <= '0;
         aw_hold_q <= 1'b0;
         ar_hold_q <= 1'b0;
         w_hold_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         w_open_q  <= w_open_d;
         aw_hold_q <= aw_hold_d;
         ar_hold_q <= ar_hold_d;
         w_hold_q  <= w_hold_d;
      end
   end

   assign isolated_o = (state_q == ISOLATED);

`ifdef AXI_CDC_SRC_ISOLATE_TIMEOUT_EN
   localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
   localparam logic [ToW-1:0] ToMax = ToW'(TimeoutCycles);

   logic [ToW-1:0] drain_cnt_q, drain_cnt_d;
   logic           timeout_q, timeout_d;

   // The counter sits at zero outside DRAIN, so entry always starts from 0.
   always_comb begin
      drain_cnt_d = '0;
      timeout_d   = 1'b0;
      if ((state_d == DRAIN) && (state_q == DRAIN)) begin
         drain_cnt_d = drain_cnt_q;
         timeout_d   = timeout_q;
         if (drain_cnt_q != ToMax) drain_cnt_d = drain_cnt_q + 1'b1;
         if (drain_cnt_d == ToMax) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         drain_cnt_q <= drain_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`endif

`ifndef SYNTHESIS
   wr_underflow_a: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
      !(b_hs && !aw_hs && (wr_cnt_q == '0)));
   rd_underflow_a: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
      !(r_last_hs && !ar_hs && (rd_cnt_q == '0)));
`endif

endmodule
